mem_addr_stage: RTL and testbench
=================================

Name: mem_addr_stage

Overview:
- Load/store address-and-access stage; sits directly downstream of the sign/shift extender.
- Consumes the extender's 32-bit shift_result as the addressing-mode offset and combines it with the base register value.
- Forms the effective address with pre/post-index and up/down rules, and runs one data-memory transaction through a req/ack handshake.
- Hands the load result and base-writeback to the register-write stage through a valid/ready interface.

Parameters:
- ADDR_W, 32, width of addresses, base and offset.
- DATA_W, 32, data width; fixed at 32 for byte-lane logic.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  upstream holds a valid transfer.
- in_ready  out  1  stage accepts the transfer this cycle.
- base  in  32  Rn value.
- offset  in  32  shift_result from the extender.
- u_bit  in  1  1 = add offset, 0 = subtract.
- p_bit  in  1  1 = pre-index, 0 = post-index.
- w_bit  in  1  base writeback request (pre-index only).
- b_bit  in  1  1 = byte access, 0 = word.
- l_bit  in  1  1 = load, 0 = store.
- store_data  in  32  Rd value for stores.
- rd_idx  in  4  destination/source register index.
- rn_idx  in  4  base register index.
- mem_req  out  1  memory request.
- mem_we  out  1  write enable.
- mem_byte  out  1  byte access.
- mem_addr  out  32  word-aligned address for word accesses; exact address for bytes.
- mem_wdata  out  32  write data.
- mem_ack  in  1  memory completes the transaction.
- mem_rdata  in  32  read data, valid with mem_ack.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts the result.
- rd_we  out  1  write load data to Rd.
- rd_out_idx  out  4  Rd index.
- rd_data  out  32  load result.
- rn_we  out  1  write back the base register.
- rn_out_idx  out  4  Rn index.
- rn_data  out  32  updated base.
- busy  out  1  state != IDLE.

Behaviour:
- Reset: on the reset edge the state goes to IDLE and every output is 0, including in_ready. in_ready rises the first cycle after reset deasserts.
- Reset mid-transaction: the transaction is abandoned and mem_req is low the next cycle. A late mem_ack while in IDLE is ignored.
- States:
  - IDLE: in_ready = 1. When in_valid is high, all inputs are latched and the state goes to ACCESS.
  - ACCESS: mem_req = 1, address, data and controls held stable until mem_ack. On mem_ack, mem_rdata is latched and the state goes to RESP. mem_ack in the first ACCESS cycle is legal, giving minimum 1-cycle memory latency.
  - RESP: out_valid = 1, all out fields held stable until out_ready. On out_ready the state returns to IDLE.
- in_ready is high only in IDLE; there is no same-cycle turnaround. Minimum occupancy is 3 cycles per transfer.
- Arithmetic:
  - sum = u_bit ? base+offset : base-offset, modulo 2^32 (wrap is silent, no flag).
  - ea = p_bit ? sum : base.
  - mem_addr = b_bit ? ea : {ea[31:2], 2'b00}.
- Base writeback: rn_we = (!p_bit or w_bit) and sum is written as rn_data.
- Store data:
  - Word store: mem_wdata = store_data.
  - Byte store: store_data[7:0] replicated to all four lanes.
  - rd_we = 0 for stores.
- Load data:
  - Byte load: rd_data = zero-extended lane ea[1:0] of mem_rdata.
  - Word load: rd_data = mem_rdata rotated right by 8*ea[1:0]. Lane 0 = bits 7:0.
  - rd_we = 1 for loads.
- Conflict: load with writeback and rd_idx == rn_idx → rd_we = 1 and rn_we forced to 0; the load data wins.
- The out fields are 0 whenever out_valid = 0.

Decomposition:
- Shared package holds:
  - the state encoding (IDLE = 2'd0, ACCESS = 2'd1, RESP = 2'd2);
  - lane-index constants;
  - the addressing-bit positions U = 23, P = 24, W = 21, B = 22, L = 20, for the decoder that drives this stage.
- One sub-module, mem_lane_align: combinational byte-lane select/zero-extend and word rotate for loads, plus byte replication for stores.

Test Plan:
- Pre-index add, no writeback: base=0x1000, offset=0x10, U=1 P=1 W=0 L=1 W-access, mem_rdata=0xDEADBEEF → mem_addr=0x1010, rd_data=0xDEADBEEF, rd_we=1, rn_we=0.
- Post-index subtract store: base=0x2000, offset=4, U=0 P=0, store_data=0x12345678 → mem_addr=0x2000, mem_we=1, rn_we=1, rn_data=0x1FFC, rd_we=0.
- Byte load at lane 3: base=0x3003, offset=0, P=1, mem_rdata=0xAB000000 → mem_addr=0x3003, rd_data=0x000000AB. Byte store of 0x5A → mem_wdata=0x5A5A5A5A.
- Wrap and rotate: base=0xFFFFFFFE, offset=3, U=1 P=1 W=1, word load, mem_rdata=0x11223344 → ea=0x00000001, mem_addr=0, rd_data=0x44112233, rn_data=0x00000001.
- Handshake stalls: hold mem_ack low for 5 cycles then out_ready low for 3 → mem_req stays high and stable for 6 cycles, out fields stable while out_valid=1, in_ready=0 throughout. Conflict case rd_idx=rn_idx=4 load with W=1 → rn_we=0.
- Reset during ACCESS with mem_req=1 → next cycle mem_req=0, busy=0, out_valid=0. A mem_ack pulse right after reset does not raise out_valid.

Source files
------------

// File: rtl/mem_addr_stage_pkg.sv
// Shared types and constants for the load/store address-and-access stage.
package mem_addr_stage_pkg;

  localparam int unsigned MA_ADDR_W = 32;
  localparam int unsigned MA_DATA_W = 32;
  localparam int unsigned MA_IDX_W  = 4;
  localparam int unsigned MA_LANE_W = 2;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_e;

  localparam logic [MA_LANE_W-1:0] LANE0 = 2'd0;
  localparam logic [MA_LANE_W-1:0] LANE1 = 2'd1;
  localparam logic [MA_LANE_W-1:0] LANE2 = 2'd2;
  localparam logic [MA_LANE_W-1:0] LANE3 = 2'd3;

  // Addressing-bit positions in the instruction word, for the upstream decoder.
  localparam int unsigned BIT_L = 20;
  localparam int unsigned BIT_W = 21;
  localparam int unsigned BIT_B = 22;
  localparam int unsigned BIT_U = 23;
  localparam int unsigned BIT_P = 24;

  typedef struct packed {
    logic [MA_ADDR_W-1:0] addr;
    logic [MA_DATA_W-1:0] wdata;
    logic                 we;
    logic                 byte_acc;
  } mem_cmd_t;

  typedef struct packed {
    logic                 rd_we;
    logic [MA_IDX_W-1:0]  rd_idx;
    logic [MA_DATA_W-1:0] rd_data;
    logic                 rn_we;
    logic [MA_IDX_W-1:0]  rn_idx;
    logic [MA_ADDR_W-1:0] rn_data;
  } resp_t;

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane alignment: load lane select/zero-extend or word rotate, store byte replication.
module mem_lane_align
  import mem_addr_stage_pkg::*;
(
  input  logic [MA_DATA_W-1:0] rdata_i,
  input  logic [MA_LANE_W-1:0] lane_i,
  input  logic                 ld_byte_i,
  input  logic [MA_DATA_W-1:0] st_data_i,
  input  logic                 st_byte_i,
  output logic [MA_DATA_W-1:0] ld_data_c_o,
  output logic [MA_DATA_W-1:0] st_data_c_o
);

  logic [7:0]           ld_byte;
  logic [MA_DATA_W-1:0] ld_rot;

  // Lane 0 is bits 7:0; a word load rotates right by 8*lane.
  always_comb begin
    ld_byte = rdata_i[7:0];
    ld_rot  = rdata_i;
    case (lane_i)
      LANE1: begin
        ld_byte = rdata_i[15:8];
        ld_rot  = {rdata_i[7:0], rdata_i[31:8]};
      end
      LANE2: begin
        ld_byte = rdata_i[23:16];
        ld_rot  = {rdata_i[15:0], rdata_i[31:16]};
      end
      LANE3: begin
        ld_byte = rdata_i[31:24];
        ld_rot  = {rdata_i[23:0], rdata_i[31:24]};
      end
      default: begin
        ld_byte = rdata_i[7:0];
        ld_rot  = rdata_i;
      end
    endcase
  end

  assign ld_data_c_o = ld_byte_i ? {24'h0, ld_byte} : ld_rot;
  assign st_data_c_o = st_byte_i ? {4{st_data_i[7:0]}} : st_data_i;

endmodule

// File: rtl/mem_addr_stage.sv
// Load/store stage: effective address, one req/ack memory access, valid/ready result.
module mem_addr_stage
  import mem_addr_stage_pkg::*;
#(
  parameter int unsigned ADDR_W = MA_ADDR_W,
  parameter int unsigned DATA_W = MA_DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ADDR_W-1:0] base,
  input  logic [ADDR_W-1:0] offset,
  input  logic              u_bit,
  input  logic              p_bit,
  input  logic              w_bit,
  input  logic              b_bit,
  input  logic              l_bit,
  input  logic [DATA_W-1:0] store_data,
  input  logic [3:0]        rd_idx,
  input  logic [3:0]        rn_idx,
  output logic              mem_req,
  output logic              mem_we,
  output logic              mem_byte,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              rd_we,
  output logic [3:0]        rd_out_idx,
  output logic [DATA_W-1:0] rd_data,
  output logic              rn_we,
  output logic [3:0]        rn_out_idx,
  output logic [ADDR_W-1:0] rn_data,
  output logic              busy
);

  state_e               state_q, state_d;
  mem_cmd_t             mem_q, mem_d;
  resp_t                pend_q, pend_d;
  resp_t                resp_q, resp_d;
  logic [MA_LANE_W-1:0] lane_q, lane_d;
  logic                 mem_req_q, mem_req_d;
  logic                 out_valid_q, out_valid_d;
  logic                 in_ready_q, in_ready_d;
  logic                 busy_q, busy_d;

  logic [ADDR_W-1:0]    sum;
  logic [ADDR_W-1:0]    ea;
  logic                 wb_req;
  logic                 wb_conflict;
  logic [DATA_W-1:0]    ld_data_c;
  logic [DATA_W-1:0]    st_data_c;

  assign sum         = u_bit ? (base + offset) : (base - offset);
  assign ea          = p_bit ? sum : base;
  assign wb_req      = !p_bit || w_bit;
  assign wb_conflict = l_bit && wb_req && (rd_idx == rn_idx);

  mem_lane_align u_align (
    .rdata_i     (mem_rdata),
    .lane_i      (lane_q),
    .ld_byte_i   (mem_q.byte_acc),
    .st_data_i   (store_data),
    .st_byte_i   (b_bit),
    .ld_data_c_o (ld_data_c),
    .st_data_c_o (st_data_c)
  );

  always_comb begin
    state_d     = state_q;
    mem_d       = mem_q;
    pend_d      = pend_q;
    resp_d      = resp_q;
    lane_d      = lane_q;
    mem_req_d   = mem_req_q;
    out_valid_d = out_valid_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid && in_ready_q) begin
          mem_d.addr     = b_bit ? ea : {ea[ADDR_W-1:2], 2'b00};
          mem_d.wdata    = st_data_c;
          mem_d.we       = !l_bit;
          mem_d.byte_acc = b_bit;
          lane_d         = ea[1:0];
          pend_d.rd_we   = l_bit;
          pend_d.rd_idx  = rd_idx;
          pend_d.rd_data = '0;
          pend_d.rn_we   = wb_req && !wb_conflict;
          pend_d.rn_idx  = rn_idx;
          pend_d.rn_data = sum;
          mem_req_d      = 1'b1;
          state_d        = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        if (mem_ack) begin
          resp_d         = pend_q;
          resp_d.rd_data = pend_q.rd_we ? ld_data_c : '0;
          mem_d          = '0;
          mem_req_d      = 1'b0;
          out_valid_d    = 1'b1;
          state_d        = ST_RESP;
        end
      end
      ST_RESP: begin
        if (out_ready) begin
          resp_d      = '0;
          out_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    in_ready_d = (state_d == ST_IDLE);
    busy_d     = (state_d != ST_IDLE);
  end

  // Reset clears every output flop, so in_ready only rises one cycle after release.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      mem_q       <= '0;
      pend_q      <= '0;
      resp_q      <= '0;
      lane_q      <= '0;
      mem_req_q   <= 1'b0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      mem_q       <= mem_d;
      pend_q      <= pend_d;
      resp_q      <= resp_d;
      lane_q      <= lane_d;
      mem_req_q   <= mem_req_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
      busy_q      <= busy_d;
    end
  end

  assign in_ready   = in_ready_q;
  assign busy       = busy_q;
  assign mem_req    = mem_req_q;
  assign mem_we     = mem_q.we;
  assign mem_byte   = mem_q.byte_acc;
  assign mem_addr   = mem_q.addr;
  assign mem_wdata  = mem_q.wdata;
  assign out_valid  = out_valid_q;
  assign rd_we      = resp_q.rd_we;
  assign rd_out_idx = resp_q.rd_idx;
  assign rd_data    = resp_q.rd_data;
  assign rn_we      = resp_q.rn_we;
  assign rn_out_idx = resp_q.rn_idx;
  assign rn_data    = resp_q.rn_data;

endmodule

// File: tb/tb_mem_addr_stage.sv
// Directed self-checking bench for mem_addr_stage with hand-computed expectations.
module tb_mem_addr_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid, in_ready;
  logic [31:0] base, offset, store_data;
  logic        u_bit, p_bit, w_bit, b_bit, l_bit;
  logic [3:0]  rd_idx, rn_idx;
  logic        mem_req, mem_we, mem_byte, mem_ack;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        out_valid, out_ready, rd_we, rn_we, busy;
  logic [3:0]  rd_out_idx, rn_out_idx;
  logic [31:0] rd_data, rn_data;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  mem_addr_stage dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .base(base), .offset(offset),
    .u_bit(u_bit), .p_bit(p_bit), .w_bit(w_bit), .b_bit(b_bit), .l_bit(l_bit),
    .store_data(store_data), .rd_idx(rd_idx), .rn_idx(rn_idx),
    .mem_req(mem_req), .mem_we(mem_we), .mem_byte(mem_byte),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .out_valid(out_valid), .out_ready(out_ready),
    .rd_we(rd_we), .rd_out_idx(rd_out_idx), .rd_data(rd_data),
    .rn_we(rn_we), .rn_out_idx(rn_out_idx), .rn_data(rn_data),
    .busy(busy)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic txn(input string name,
                     input logic [31:0] b_v, input logic [31:0] o_v,
                     input logic u, input logic p, input logic w,
                     input logic bb, input logic l,
                     input logic [31:0] sdata, input logic [3:0] rd, input logic [3:0] rn,
                     input logic [31:0] rdata, input int ack_dly, input int rdy_dly,
                     input logic [31:0] e_addr, input logic [31:0] e_wdata,
                     input logic [31:0] e_rd_data, input logic e_rn_we,
                     input logic [31:0] e_rn_data);
    int guard;
    int req_cycles;
    guard = 0;
    req_cycles = 0;
    while (!in_ready && guard < 20) begin
      step();
      guard++;
    end
    check({name, ".in_ready_wait"}, 32'(in_ready), 32'd1);
    base = b_v; offset = o_v; u_bit = u; p_bit = p; w_bit = w; b_bit = bb; l_bit = l;
    store_data = sdata; rd_idx = rd; rn_idx = rn;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    base = 32'hFFFF_FFFF; offset = 32'hFFFF_FFFF; store_data = 32'hFFFF_FFFF;
    for (int i = 0; i <= ack_dly; i++) begin
      if (mem_req) req_cycles++;
      check({name, ".mem_req"}, 32'(mem_req), 32'd1);
      check({name, ".mem_addr"}, mem_addr, e_addr);
      check({name, ".mem_we"}, 32'(mem_we), 32'(!l));
      check({name, ".mem_byte"}, 32'(mem_byte), 32'(bb));
      check({name, ".in_ready_acc"}, 32'(in_ready), 32'd0);
      check({name, ".out_valid_acc"}, 32'(out_valid), 32'd0);
      if (!l) check({name, ".mem_wdata"}, mem_wdata, e_wdata);
      if (i == ack_dly) begin
        mem_ack = 1'b1;
        mem_rdata = rdata;
      end else begin
        mem_rdata = ~rdata;
      end
      step();
    end
    mem_ack = 1'b0;
    mem_rdata = 32'h0;
    check({name, ".req_cycles"}, 32'(req_cycles), 32'(ack_dly + 1));
    for (int i = 0; i <= rdy_dly; i++) begin
      check({name, ".out_valid"}, 32'(out_valid), 32'd1);
      check({name, ".mem_req_resp"}, 32'(mem_req), 32'd0);
      check({name, ".in_ready_resp"}, 32'(in_ready), 32'd0);
      check({name, ".busy"}, 32'(busy), 32'd1);
      check({name, ".rd_we"}, 32'(rd_we), 32'(l));
      check({name, ".rd_out_idx"}, 32'(rd_out_idx), 32'(rd));
      check({name, ".rn_we"}, 32'(rn_we), 32'(e_rn_we));
      check({name, ".rn_out_idx"}, 32'(rn_out_idx), 32'(rn));
      check({name, ".rn_data"}, rn_data, e_rn_data);
      if (l) check({name, ".rd_data"}, rd_data, e_rd_data);
      if (i == rdy_dly) out_ready = 1'b1;
      step();
    end
    out_ready = 1'b0;
    check({name, ".out_valid_done"}, 32'(out_valid), 32'd0);
    check({name, ".rd_we_done"}, 32'(rd_we), 32'd0);
    check({name, ".rn_data_done"}, rn_data, 32'd0);
    check({name, ".in_ready_done"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    #400000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; in_valid = 1'b0; base = '0; offset = '0; store_data = '0;
    u_bit = 1'b0; p_bit = 1'b0; w_bit = 1'b0; b_bit = 1'b0; l_bit = 1'b0;
    rd_idx = '0; rn_idx = '0; mem_ack = 1'b0; mem_rdata = '0; out_ready = 1'b0;
    step();
    step();
    check("rst.in_ready", 32'(in_ready), 32'd0);
    check("rst.mem_req", 32'(mem_req), 32'd0);
    check("rst.out_valid", 32'(out_valid), 32'd0);
    check("rst.busy", 32'(busy), 32'd0);
    check("rst.mem_addr", mem_addr, 32'd0);
    check("rst.rn_data", rn_data, 32'd0);
    reset = 1'b0;
    step();
    check("rel.in_ready", 32'(in_ready), 32'd1);
    check("rel.busy", 32'(busy), 32'd0);

    //   name       base          offset        U    P    W    B    L    sdata          rd    rn    rdata          ack rdy addr           wdata          rd_data        rnwe rn_data
    txn("pre_add",  32'h0000_1000, 32'h0000_0010, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 32'h0, 4'd1, 4'd2, 32'hDEAD_BEEF, 0, 0, 32'h0000_1010, 32'h0,         32'hDEAD_BEEF, 1'b0, 32'h0000_1010);
    txn("post_st",  32'h0000_2000, 32'h0000_0004, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h1234_5678, 4'd3, 4'd5, 32'h0, 0, 0, 32'h0000_2000, 32'h1234_5678, 32'h0,   1'b1, 32'h0000_1FFC);
    txn("ldb_l3",   32'h0000_3003, 32'h0000_0000, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 32'h0, 4'd6, 4'd7, 32'hAB00_0000, 0, 0, 32'h0000_3003, 32'h0,         32'h0000_00AB, 1'b0, 32'h0000_3003);
    txn("stb_rep",  32'h0000_4001, 32'h0000_0001, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 32'h1234_565A, 4'd8, 4'd9, 32'h0, 0, 0, 32'h0000_4002, 32'h5A5A_5A5A, 32'h0,   1'b0, 32'h0000_4002);
    txn("wrap_rot", 32'hFFFF_FFFE, 32'h0000_0003, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 32'h0, 4'd1, 4'd2, 32'h1122_3344, 0, 0, 32'h0000_0000, 32'h0,         32'h4411_2233, 1'b1, 32'h0000_0001);
    txn("rot_l2",   32'h0000_0502, 32'h0000_0100, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 4'd10, 4'd11, 32'h1122_3344, 1, 1, 32'h0000_0500, 32'h0,       32'h3344_1122, 1'b1, 32'h0000_0602);
    txn("ldb_l1",   32'h0000_0801, 32'h0000_0010, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0, 4'd12, 4'd13, 32'h1122_33C4, 0, 0, 32'h0000_0801, 32'h0,       32'h0000_0033, 1'b1, 32'h0000_07F1);
    txn("stall",    32'h0000_6000, 32'h0000_0020, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'hA5A5_0F0F, 4'd3, 4'd5, 32'h0, 5, 3, 32'h0000_6020, 32'hA5A5_0F0F, 32'h0, 1'b1, 32'h0000_6020);
    txn("conflict", 32'h0000_0100, 32'h0000_0008, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 32'h0, 4'd4, 4'd4, 32'hCAFE_F00D, 2, 0, 32'h0000_0108, 32'h0,         32'hCAFE_F00D, 1'b0, 32'h0000_0108);

    // Abandon a transaction by reset while the memory request is outstanding.
    base = 32'h0000_7000; offset = 32'h4; u_bit = 1'b1; p_bit = 1'b1; w_bit = 1'b0;
    b_bit = 1'b0; l_bit = 1'b1; rd_idx = 4'd1; rn_idx = 4'd2;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    check("mid.mem_req_before", 32'(mem_req), 32'd1);
    reset = 1'b1;
    step();
    check("mid.mem_req", 32'(mem_req), 32'd0);
    check("mid.busy", 32'(busy), 32'd0);
    check("mid.out_valid", 32'(out_valid), 32'd0);
    check("mid.in_ready", 32'(in_ready), 32'd0);
    reset = 1'b0;
    mem_ack = 1'b1;
    mem_rdata = 32'h5555_AAAA;
    step();
    mem_ack = 1'b0;
    check("late_ack.out_valid", 32'(out_valid), 32'd0);
    check("late_ack.mem_req", 32'(mem_req), 32'd0);
    check("late_ack.in_ready", 32'(in_ready), 32'd1);
    step();
    check("late_ack.out_valid2", 32'(out_valid), 32'd0);
    check("late_ack.busy", 32'(busy), 32'd0);

    txn("recover",  32'h0000_9000, 32'h0000_0008, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 32'h0, 4'd2, 4'd3, 32'h0BAD_F00D, 0, 0, 32'h0000_8FF8, 32'h0,         32'h0BAD_F00D, 1'b1, 32'h0000_8FF8);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
